// File: rtl/tx_packet_scheduler.sv
// Two-source round-robin packet scheduler for the serial transmitter.
// Each granted packet goes out as a command frame followed by a value frame.
module tx_packet_scheduler #(
  parameter int unsigned FRAME_CYCLES = 12
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] cmd_a,
  input  logic [7:0] val_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] cmd_b,
  input  logic [7:0] val_b,
  output logic       ack_b,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] pkt_count
);

  // Handshake: a source raises req_x with cmd_x/val_x valid and holds them
  // until the one-cycle ack_x pulse; the bytes are captured on that same edge.

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  // SEND consumes one cycle of the frame and the zero-count edge another.
  localparam logic [7:0] RELOAD = 8'(FRAME_CYCLES - 2);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       byte_idx_q, byte_idx_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] val_q, val_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic [7:0] pkt_count_q, pkt_count_d;
  logic       grant_b;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    cmd_d       = cmd_q;
    val_d       = val_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    pkt_count_d = pkt_count_q;
    grant_b     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // ptr_q=1 means B holds priority when both sources request.
          grant_b    = req_b && (!req_a || ptr_q);
          cmd_d      = grant_b ? cmd_b : cmd_a;
          val_d      = grant_b ? val_b : val_a;
          ack_a_d    = !grant_b;
          ack_b_d    = grant_b;
          tx_start_d = 1'b1;
          tx_data_d  = grant_b ? cmd_b : cmd_a;
          busy_d     = 1'b1;
          byte_idx_d = 1'b0;
          cnt_d      = RELOAD;
          ptr_d      = !grant_b;
          state_d    = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (cnt_q == 8'd0) begin
          if (!byte_idx_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = val_q;
            byte_idx_d = 1'b1;
            cnt_d      = RELOAD;
            state_d    = SEND;
          end else begin
            busy_d      = 1'b0;
            pkt_count_d = pkt_count_q + 8'd1;
            state_d     = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= 8'd0;
      byte_idx_q  <= 1'b0;
      cmd_q       <= 8'd0;
      val_q       <= 8'd0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      busy_q      <= 1'b0;
      pkt_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      cmd_q       <= cmd_d;
      val_q       <= val_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Randomized scoreboard bench for tx_packet_scheduler: a timestamp-level model
// predicts every tx_start event and packet completion; a monitor checks them.
module tb_tx_packet_scheduler;

  localparam int F  = 12;
  localparam int SW = 43;  // {cycle, ack_a, ack_b, busy, tx_data}
  localparam int DW = 40;  // {cycle, pkt_count}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] cmd_a = 8'h00, val_a = 8'h00, cmd_b = 8'h00, val_b = 8'h00;
  logic       ack_a, ack_b, tx_start, busy;
  logic [7:0] tx_data, pkt_count;

  tx_packet_scheduler #(.FRAME_CYCLES(F)) dut (
    .clk_115200hz(clk),
    .reset(reset),
    .req_a(req_a),
    .cmd_a(cmd_a),
    .val_a(val_a),
    .ack_a(ack_a),
    .req_b(req_b),
    .cmd_b(cmd_b),
    .val_b(val_b),
    .ack_b(ack_b),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .busy(busy),
    .pkt_count(pkt_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Scheduler is free from free_at onward; a grant at cycle t produces starts
  // at t and t+F, completion at t+2F, and frees the scheduler at t+2F+1.
  logic [SW-1:0] start_q[$];
  logic [DW-1:0] done_q[$];
  int unsigned   cyc = 0;
  int unsigned   free_at = 0;
  bit            prio_b = 1'b0;
  logic [7:0]    mcount = 8'd0;
  bit            g_b;
  logic [7:0]    g_cmd, g_val;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      prio_b  = 1'b0;
      free_at = 0;
      mcount  = 8'd0;
      start_q.delete();
      done_q.delete();
    end else if (cyc >= free_at && (req_a || req_b)) begin
      g_b   = req_b && (!req_a || prio_b);
      g_cmd = g_b ? cmd_b : cmd_a;
      g_val = g_b ? val_b : val_a;
      start_q.push_back({cyc, !g_b, g_b, 1'b1, g_cmd});
      start_q.push_back({cyc + F, 1'b0, 1'b0, 1'b1, g_val});
      mcount = mcount + 8'd1;
      done_q.push_back({cyc + 2 * F, mcount});
      free_at = cyc + 2 * F + 1;
      prio_b  = !g_b;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_busy = 1'b0;
  logic [7:0]  held = 8'h00;
  int unsigned n_starts = 0;
  int unsigned n_done = 0;
  logic [SW-1:0] se;
  logic [DW-1:0] de;

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      held      = 8'h00;
    end else begin
      if (tx_start) begin
        n_starts++;
        if (start_q.size() == 0) begin
          chk("unexpected_tx_start", {cyc, ack_a, ack_b, busy, tx_data}, 64'd0);
        end else begin
          se = start_q.pop_front();
          chk("tx_start_event", {cyc, ack_a, ack_b, busy, tx_data}, se);
        end
        held = tx_data;
      end else begin
        chk("ack_without_start", {ack_a, ack_b}, 2'b00);
        if (busy) chk("tx_data_hold", tx_data, held);
      end
      if (prev_busy && !busy) begin
        n_done++;
        if (done_q.size() == 0) begin
          chk("unexpected_done", {cyc, pkt_count}, 64'd0);
        end else begin
          de = done_q.pop_front();
          chk("packet_done", {cyc, pkt_count}, de);
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- source drivers ----------------
  bit auto_a = 0, auto_b = 0, rnd_a = 0, rnd_b = 0;
  int rate_a = 0, rate_b = 0;

  always @(negedge clk) begin
    if (ack_a) begin
      req_a = 1'b0;
      if (rnd_a) begin cmd_a = 8'($urandom); val_a = 8'($urandom); end
    end
    if (auto_a && !req_a && $urandom_range(99) < rate_a) begin
      req_a = 1'b1;
      if (rnd_a) begin cmd_a = 8'($urandom); val_a = 8'($urandom); end
    end
  end

  always @(negedge clk) begin
    if (ack_b) begin
      req_b = 1'b0;
      if (rnd_b) begin cmd_b = 8'($urandom); val_b = 8'($urandom); end
    end
    if (auto_b && !req_b && $urandom_range(99) < rate_b) begin
      req_b = 1'b1;
      if (rnd_b) begin cmd_b = 8'($urandom); val_b = 8'($urandom); end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (req_a || req_b || busy || start_q.size() != 0 || done_q.size() != 0)) begin
      @(negedge clk);
      i++;
    end
    chk("drain_timeout", {req_a, req_b, busy, 16'(start_q.size()), 16'(done_q.size())}, 64'd0);
  endtask

  task automatic wait_done(input int unsigned target, input int budget);
    int i;
    i = 0;
    while (i < budget && n_done < target) begin
      @(negedge clk);
      i++;
    end
    chk("wait_done_timeout", 64'(n_done >= target), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx_start"}, tx_start, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_pkt_count"}, pkt_count, 8'h00);
    chk({tag, "_acks"}, {ack_a, ack_b}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  int unsigned s0, d0;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check_reset_values("idle");

    // single packet from A; cmd/val scrambled after ack
    rnd_a = 1;
    cmd_a = 8'h0A; val_a = 8'h3C; req_a = 1'b1;
    drain(200);
    chk("pkt_count_after_first", pkt_count, 8'd1);

    // both held continuously with fixed bytes
    rnd_a = 0; rnd_b = 0;
    cmd_a = 8'h01; val_a = 8'h11; cmd_b = 8'h02; val_b = 8'h22;
    rate_a = 100; rate_b = 100;
    d0 = n_done;
    auto_a = 1; auto_b = 1;
    wait_done(d0 + 6, 400);
    auto_a = 0; auto_b = 0;
    drain(200);

    // B arrives while A is mid-flight; A's bytes change after ack
    rnd_a = 1;
    cmd_a = 8'h5A; val_a = 8'hA5; req_a = 1'b1;
    repeat (6) @(negedge clk);
    cmd_b = 8'h77; val_b = 8'h88; req_b = 1'b1;
    drain(200);

    // reset 5 cycles into A's second frame
    cmd_a = 8'h33; val_a = 8'h44; req_a = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 100 && n_starts < s0 + 2; i++) @(negedge clk);
    chk("second_start_seen", 64'(n_starts >= s0 + 2), 64'd1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    start_q.delete();
    done_q.delete();
    @(negedge clk);
    cmd_a = 8'hC1; val_a = 8'hC2; req_a = 1'b1;
    cmd_b = 8'hD1; val_b = 8'hD2; req_b = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drain(300);
    chk("pkt_count_after_reset_pair", pkt_count, 8'd2);

    // randomized traffic
    rnd_a = 1; rnd_b = 1;
    rate_a = $urandom_range(60, 5); rate_b = $urandom_range(60, 5);
    auto_a = 1; auto_b = 1;
    repeat (3000) @(negedge clk);
    auto_a = 0; auto_b = 0;
    drain(200);

    // continuous traffic past the 255->0 wrap of pkt_count
    rate_a = 100; rate_b = 100;
    d0 = n_done;
    auto_a = 1; auto_b = 1;
    wait_done(d0 + 260, 260 * (2 * F + 1) + 200);
    auto_a = 0; auto_b = 0;
    drain(200);
    chk("pkt_count_model_final", pkt_count, mcount);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
